// File: rtl/data_path_gen.sv
// Parametrised, fully clocked CPU data path: PC, MAR, IR, register file,
// 8-op ALU and registered NZVC condition codes.
module data_path_gen #(
  parameter  int WIDTH  = 8,
  parameter  int NREGS  = 4,
  localparam int RSEL_W = $clog2(NREGS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [WIDTH-1:0]  from_memory,
  input  logic [2:0]        ALU_Sel,
  input  logic [1:0]        Bus1_Sel,
  input  logic [RSEL_W-1:0] Bus1_Reg,
  input  logic [1:0]        Bus2_Sel,
  input  logic [RSEL_W-1:0] ALU_B_Reg,
  input  logic [RSEL_W-1:0] Reg_Dst,
  input  logic              IR_Load,
  input  logic              MAR_Load,
  input  logic              PC_Load,
  input  logic              Reg_Load,
  input  logic              CCR_Load,
  input  logic              PC_Inc,
  output logic [WIDTH-1:0]  address,
  output logic [WIDTH-1:0]  to_memory,
  output logic [WIDTH-1:0]  IR_out,
  output logic [3:0]        CCR_Result
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] mar_q, mar_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [3:0]       ccr_q, ccr_d;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] rf_d [NREGS];

  logic [WIDTH-1:0] bus1;
  logic [WIDTH-1:0] bus2;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   dif_x;
  logic             flag_c;
  logic             flag_v;

  always_comb begin
    case (Bus1_Sel)
      2'b00:   bus1 = pc_q;
      2'b01:   bus1 = rf_q[Bus1_Reg];
      2'b10:   bus1 = ir_q;
      default: bus1 = '0;
    endcase
  end

  assign alu_b = rf_q[ALU_B_Reg];
  assign sum_x = {1'b0, bus1} + {1'b0, alu_b};
  assign dif_x = {1'b0, bus1} - {1'b0, alu_b};

  // dif_x[WIDTH] is the unsigned borrow (A < B)
  always_comb begin
    alu_res = '0;
    flag_c  = 1'b0;
    flag_v  = 1'b0;
    case (ALU_Sel)
      3'b000: begin
        alu_res = sum_x[MSB:0];
        flag_c  = sum_x[WIDTH];
        flag_v  = (bus1[MSB] == alu_b[MSB]) &&
                  (alu_res[MSB] != bus1[MSB]);
      end
      3'b001: begin
        alu_res = dif_x[MSB:0];
        flag_c  = dif_x[WIDTH];
        flag_v  = (bus1[MSB] != alu_b[MSB]) &&
                  (alu_res[MSB] != bus1[MSB]);
      end
      3'b010: alu_res = bus1 & alu_b;
      3'b011: alu_res = bus1 | alu_b;
      3'b100: alu_res = bus1 ^ alu_b;
      3'b101: begin
        alu_res = {bus1[MSB-1:0], 1'b0};
        flag_c  = bus1[MSB];
      end
      3'b110: begin
        alu_res = {1'b0, bus1[MSB:1]};
        flag_c  = bus1[0];
      end
      default: alu_res = ~bus1;
    endcase
  end

  always_comb begin
    case (Bus2_Sel)
      2'b00:   bus2 = alu_res;
      2'b01:   bus2 = bus1;
      2'b10:   bus2 = from_memory;
      default: bus2 = '0;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    mar_d = mar_q;
    ir_d  = ir_q;
    ccr_d = ccr_q;
    rf_d  = rf_q;
    if (PC_Load)     pc_d = bus2;
    else if (PC_Inc) pc_d = pc_q + 1'b1;
    if (MAR_Load)    mar_d = bus2;
    if (IR_Load)     ir_d  = bus2;
    if (Reg_Load)    rf_d[Reg_Dst] = bus2;
    if (CCR_Load)    ccr_d = {alu_res[MSB], ~|alu_res, flag_v, flag_c};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= '0;
      mar_q <= '0;
      ir_q  <= '0;
      ccr_q <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      ir_q  <= ir_d;
      ccr_q <= ccr_d;
      rf_q  <= rf_d;
    end
  end

  assign address    = mar_q;
  assign to_memory  = bus1;
  assign IR_out     = ir_q;
  assign CCR_Result = ccr_q;

endmodule

// File: tb/tb_data_path_gen.sv
// Directed bench for data_path_gen: one 8-bit/4-reg and one
// 16-bit/8-reg instance driven by shared stimulus.
module tb_data_path_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] from_mem;
  logic [2:0]  alu_sel;
  logic [1:0]  b1_sel, b2_sel;
  logic [2:0]  b1_reg, b_reg, dst;
  logic        ir_ld, mar_ld, pc_ld, reg_ld, ccr_ld, pc_inc;

  logic [7:0]  n_addr, n_tomem, n_ir;
  logic [3:0]  n_ccr;
  logic [15:0] w_addr, w_tomem, w_ir;
  logic [3:0]  w_ccr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  data_path_gen #(.WIDTH(8), .NREGS(4)) u_n (
    .Clk(clk), .Reset(rst), .from_memory(from_mem[7:0]),
    .ALU_Sel(alu_sel), .Bus1_Sel(b1_sel), .Bus1_Reg(b1_reg[1:0]),
    .Bus2_Sel(b2_sel), .ALU_B_Reg(b_reg[1:0]), .Reg_Dst(dst[1:0]),
    .IR_Load(ir_ld), .MAR_Load(mar_ld), .PC_Load(pc_ld),
    .Reg_Load(reg_ld), .CCR_Load(ccr_ld), .PC_Inc(pc_inc),
    .address(n_addr), .to_memory(n_tomem), .IR_out(n_ir),
    .CCR_Result(n_ccr)
  );

  data_path_gen #(.WIDTH(16), .NREGS(8)) u_w (
    .Clk(clk), .Reset(rst), .from_memory(from_mem),
    .ALU_Sel(alu_sel), .Bus1_Sel(b1_sel), .Bus1_Reg(b1_reg),
    .Bus2_Sel(b2_sel), .ALU_B_Reg(b_reg), .Reg_Dst(dst),
    .IR_Load(ir_ld), .MAR_Load(mar_ld), .PC_Load(pc_ld),
    .Reg_Load(reg_ld), .CCR_Load(ccr_ld), .PC_Inc(pc_inc),
    .address(w_addr), .to_memory(w_tomem), .IR_out(w_ir),
    .CCR_Result(w_ccr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    rst    = 1'b0;
    ir_ld  = 1'b0;
    mar_ld = 1'b0;
    pc_ld  = 1'b0;
    reg_ld = 1'b0;
    ccr_ld = 1'b0;
    pc_inc = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic ld(input logic [2:0] r, input logic [15:0] v);
    from_mem = v;
    b2_sel   = 2'b10;
    dst      = r;
    reg_ld   = 1'b1;
    tick();
  endtask

  task automatic alu(input logic [2:0] op, input logic [2:0] a,
                     input logic [2:0] b, input logic [2:0] d);
    b1_sel  = 2'b01;
    b1_reg  = a;
    b_reg   = b;
    alu_sel = op;
    b2_sel  = 2'b00;
    dst     = d;
    reg_ld  = 1'b1;
    ccr_ld  = 1'b1;
    tick();
  endtask

  task automatic rd(input string tag, input logic [2:0] r,
                    input logic [7:0] en, input logic [15:0] ew);
    b1_sel = 2'b01;
    b1_reg = r;
    #1;
    chk({tag, "_n"}, n_tomem, en);
    chk({tag, "_w"}, w_tomem, ew);
  endtask

  task automatic pc(input string tag, input logic [7:0] en,
                    input logic [15:0] ew);
    b1_sel = 2'b00;
    #1;
    chk({tag, "_n"}, n_tomem, en);
    chk({tag, "_w"}, w_tomem, ew);
  endtask

  task automatic cc(input string tag, input logic [3:0] en,
                    input logic [3:0] ew);
    chk({tag, "_n"}, n_ccr, en);
    chk({tag, "_w"}, w_ccr, ew);
  endtask

  initial begin
    idle();
    from_mem = '0;
    alu_sel  = '0;
    b1_sel   = '0;
    b2_sel   = '0;
    b1_reg   = '0;
    b_reg    = '0;
    dst      = '0;
    rst      = 1'b1;
    tick();

    chk("rst0_addr_n", n_addr, 8'h00);
    chk("rst0_addr_w", w_addr, 16'h0000);
    chk("rst0_ir_w", w_ir, 16'h0000);
    cc("rst0_ccr", 4'b0000, 4'b0000);
    pc("rst0_pc", 8'h00, 16'h0000);

    // fill everything nonzero, then reset with strobes also asserted
    ld(0, 16'h1111);
    ld(1, 16'h2222);
    ld(2, 16'h3333);
    ld(3, 16'h4444);
    from_mem = 16'hA5A5;
    b2_sel   = 2'b10;
    ir_ld    = 1'b1;
    mar_ld   = 1'b1;
    pc_ld    = 1'b1;
    tick();
    alu(3'b111, 0, 0, 3);
    chk("pre_addr_n", n_addr, 8'hA5);
    chk("pre_addr_w", w_addr, 16'hA5A5);
    cc("pre_ccr", 4'b1000, 4'b1000);
    rd("pre_r3", 3, 8'hEE, 16'hEEEE);

    rst      = 1'b1;
    from_mem = 16'hBEEF;
    b2_sel   = 2'b10;
    ir_ld    = 1'b1;
    mar_ld   = 1'b1;
    pc_ld    = 1'b1;
    reg_ld   = 1'b1;
    ccr_ld   = 1'b1;
    dst      = 3'd1;
    tick();
    chk("rst_addr_n", n_addr, 8'h00);
    chk("rst_addr_w", w_addr, 16'h0000);
    chk("rst_ir_n", n_ir, 8'h00);
    chk("rst_ir_w", w_ir, 16'h0000);
    cc("rst_ccr", 4'b0000, 4'b0000);
    pc("rst_pc", 8'h00, 16'h0000);
    for (int i = 0; i < 4; i++) rd($sformatf("rst_r%0d", i), 3'(i), 8'h00, 16'h0000);

    // fetch
    from_mem = 16'h0010;
    b2_sel   = 2'b10;
    pc_ld    = 1'b1;
    tick();
    b1_sel = 2'b00;
    b2_sel = 2'b01;
    mar_ld = 1'b1;
    tick();
    chk("fetch_mar_n", n_addr, 8'h10);
    chk("fetch_mar_w", w_addr, 16'h0010);
    from_mem = 16'h0086;
    b2_sel   = 2'b10;
    ir_ld    = 1'b1;
    pc_inc   = 1'b1;
    tick();
    chk("fetch_ir_n", n_ir, 8'h86);
    chk("fetch_ir_w", w_ir, 16'h0086);
    pc("fetch_pc", 8'h11, 16'h0011);
    b1_sel = 2'b10;
    #1;
    chk("bus1_ir_w", w_tomem, 16'h0086);

    // ALU and flags
    ld(1, 16'h007F);
    ld(2, 16'h0001);
    alu(3'b000, 1, 2, 3);
    rd("add_v", 3, 8'h80, 16'h0080);
    cc("add_v_ccr", 4'b1010, 4'b0000);
    ld(1, 16'hFFFF);
    alu(3'b000, 1, 2, 3);
    rd("add_c", 3, 8'h00, 16'h0000);
    cc("add_c_ccr", 4'b0101, 4'b0101);
    ld(1, 16'h7FFF);
    alu(3'b000, 1, 2, 3);
    rd("add_mix", 3, 8'h00, 16'h8000);
    cc("add_mix_ccr", 4'b0101, 4'b1010);
    ld(1, 16'h0003);
    ld(2, 16'h0005);
    alu(3'b001, 1, 2, 3);
    rd("sub_b", 3, 8'hFE, 16'hFFFE);
    cc("sub_b_ccr", 4'b1001, 4'b1001);
    ld(1, 16'h0080);
    ld(2, 16'h0001);
    alu(3'b001, 1, 2, 3);
    rd("sub_v", 3, 8'h7F, 16'h007F);
    cc("sub_v_ccr", 4'b0010, 4'b0000);
    ld(1, 16'h8081);
    alu(3'b101, 1, 2, 3);
    rd("shl", 3, 8'h02, 16'h0102);
    cc("shl_ccr", 4'b0001, 4'b0001);
    ld(1, 16'h0001);
    alu(3'b110, 1, 2, 3);
    rd("shr", 3, 8'h00, 16'h0000);
    cc("shr_ccr", 4'b0101, 4'b0101);
    ld(1, 16'h5A5A);
    ld(2, 16'hFFFF);
    alu(3'b100, 1, 2, 3);
    rd("xor", 3, 8'hA5, 16'hA5A5);
    cc("xor_ccr", 4'b1000, 4'b1000);
    alu(3'b010, 1, 2, 3);
    rd("and", 3, 8'h5A, 16'h5A5A);
    cc("and_ccr", 4'b0000, 4'b0000);
    ld(1, 16'h0000);
    ld(2, 16'h0000);
    alu(3'b011, 1, 2, 3);
    rd("or", 3, 8'h00, 16'h0000);
    cc("or_ccr", 4'b0100, 4'b0100);
    alu(3'b111, 1, 2, 3);
    rd("not", 3, 8'hFF, 16'hFFFF);
    cc("not_ccr", 4'b1000, 4'b1000);
    b1_sel  = 2'b11;
    alu_sel = 3'b001;
    tick();
    cc("ccr_hold", 4'b1000, 4'b1000);

    // PC wrap and load priority
    from_mem = 16'hFFFF;
    b2_sel   = 2'b10;
    pc_ld    = 1'b1;
    tick();
    pc_inc = 1'b1;
    tick();
    pc("pc_wrap", 8'h00, 16'h0000);
    from_mem = 16'h0040;
    b2_sel   = 2'b10;
    pc_ld    = 1'b1;
    pc_inc   = 1'b1;
    tick();
    pc("pc_prio", 8'h40, 16'h0040);

    // read during write
    ld(0, 16'h0022);
    from_mem = 16'h0055;
    b2_sel   = 2'b10;
    dst      = 3'd0;
    reg_ld   = 1'b1;
    rd("rdw_old", 0, 8'h22, 16'h0022);
    tick();
    rd("rdw_new", 0, 8'h55, 16'h0055);

    // multiple strobes share one Bus2 value
    from_mem = 16'h3C3C;
    b2_sel   = 2'b10;
    ir_ld    = 1'b1;
    mar_ld   = 1'b1;
    dst      = 3'd2;
    reg_ld   = 1'b1;
    tick();
    chk("multi_ir_w", w_ir, 16'h3C3C);
    chk("multi_mar_n", n_addr, 8'h3C);
    rd("multi_r2", 2, 8'h3C, 16'h3C3C);

    // upper registers of the wide instance
    ld(7, 16'h1234);
    rd("w_r7", 7, 8'h34, 16'h1234);
    b2_sel = 2'b11;
    mar_ld = 1'b1;
    tick();
    chk("bus2_zero_w", w_addr, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_path_gen.md
# data_path_gen

Parametrised, fully clocked successor to the 8-bit CPU data path. It provides a WIDTH-bit datapath with PC, MAR, IR, an NREGS-entry general register file, an 8-operation ALU and a registered NZVC condition-code register. It sits between the control-unit FSM, which drives all select and load strobes, and the memory block, which receives address/to_memory and returns from_memory.

## Interface
- WIDTH, 8, datapath and address width; legal values ≥ 2.
- NREGS, 4, general register count; a power of two ≥ 2.
- RSEL_W, $clog2(NREGS), register index width; derived, not overridden.

Clock and reset: one clock; reset is synchronous and active-high.

- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high; clears all state
- from_memory  in  WIDTH  memory read data
- ALU_Sel  in  3  ALU operation
- Bus1_Sel  in  2  Bus1 source: 00 PC, 01 R[Bus1_Reg], 10 IR, 11 zero
- Bus1_Reg  in  RSEL_W  register index for Bus1 source 01
- Bus2_Sel  in  2  Bus2 source: 00 ALU_Result, 01 Bus1, 10 from_memory, 11 zero
- ALU_B_Reg  in  RSEL_W  register index for ALU operand B
- Reg_Dst  in  RSEL_W  register-file write index
- IR_Load, MAR_Load, PC_Load, Reg_Load, CCR_Load  in  1 each  load strobes
- PC_Inc  in  1  increment PC
- address  out  WIDTH  MAR contents (registered)
- to_memory  out  WIDTH  Bus1 (combinational)
- IR_out  out  WIDTH  IR contents (registered)
- CCR_Result  out  4  {N,Z,V,C} (registered)

## Operation
- Bus1 and Bus2 are combinational muxes. Bus2 source 01 passes the current Bus1 value.
- ALU operands: A = Bus1, B = R[ALU_B_Reg].
- ALU_Sel codes:
  - 000 A+B
  - 001 A−B
  - 010 A&B
  - 011 A|B
  - 100 A^B
  - 101 A<<1
  - 110 A>>1 (logical)
  - 111 ~A
- All results are truncated to WIDTH.
- Flags are computed from ALU_Result and ALU_Sel:
  - N = MSB of the result.
  - Z = 1 when the result is all zeros.
  - V = signed two's-complement overflow for ADD/SUB; 0 for all other operations.
  - C = carry-out for ADD; borrow for SUB (A<B unsigned); shifted-out bit for SHL (A[WIDTH−1]) and SHR (A[0]); 0 for logic/NOT.
- On each rising Clk edge:
  - IR, MAR, PC, R[Reg_Dst] each load Bus2 when their strobe is set.
  - CCR loads the flags when CCR_Load is set.
  - Registers with no strobe hold their value.
- PC update priority: PC_Load over PC_Inc. PC_Inc alone gives PC+1 mod 2^WIDTH (0xFF→0x00 at WIDTH=8).
- Register-file reads are combinational with no write bypass. A read of R[k] in the same cycle as a write to R[k] returns the old value; the new value is visible the next cycle.
- Multiple strobes in one cycle are legal. All loaded registers capture the same Bus2 value, and CCR captures the flags of that cycle's ALU_Result.
- No X is ever driven. Unused mux codes select zero.

## Timing
- Reset has priority over all strobes. On the first edge with Reset=1: PC, MAR, IR, all R[i], CCR ← 0.
  - After reset: address=0, IR_out=0, CCR_Result=4'b0000.
  - to_memory follows Bus1, so it reads 0 when Bus1_Sel=00.
- Reset asserted mid-instruction discards any strobes in that cycle.
- Load latency is 1 cycle: a strobe in cycle n makes the value visible on the outputs/reads in cycle n+1.
- to_memory and ALU paths are combinational within the cycle. The only state is PC, MAR, IR, the register file and CCR.

## Test plan
- Reset: load nonzero into all registers, assert Reset one cycle → address=0, IR_out=0, CCR_Result=0, all R read 0.
- Fetch: PC=0x10, Bus1_Sel=00, Bus2_Sel=01, MAR_Load → address=0x10 next cycle. Then from_memory=0x86, Bus2_Sel=10, IR_Load, PC_Inc → IR_out=0x86, PC=0x11.
- ADD/flags (WIDTH=8): R1=0x7F, R2=0x01, Bus1=R1, B=R2, ALU 000, Bus2=00, Reg_Load R3, CCR_Load → R3=0x80, CCR=1010 (N,V). Repeat with 0xFF+0x01 → result 0x00, CCR=0101 (Z,C).
- SUB borrow and shifts: 0x03−0x05 → 0xFE, CCR=1001. SHL of 0x81 → 0x02, C=1. SHR of 0x01 → 0x00, CCR=0101.
- PC wrap/priority: PC=0xFF, PC_Inc → 0x00. PC_Load with Bus2=0x40 and PC_Inc together → PC=0x40.
- Read-during-write: write R0←0x55 while Bus1 reads R0 (old value 0x22) → to_memory=0x22 that cycle, 0x55 next. Also repeat the full suite at WIDTH=16, NREGS=8.
